// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
// Shared types and helpers for the Wishbone round-robin arbiter.
//   arb_state_e : arbiter FSM state (IDLE, BUSY)
//   rr_pick     : one-hot round-robin winner, searching upward from last+1
//                 with wrap-around over the first n request bits
package wb_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Widest arbiter supported by rr_pick; narrower ones zero-pad.
  localparam int RR_MAX = 8;

  function automatic logic [RR_MAX-1:0] rr_pick(
    input logic [RR_MAX-1:0] req,
    input logic [2:0]        last,
    input int                n
  );
    logic [RR_MAX-1:0] win;
    logic              found;
    int                idx;
    win   = '0;
    found = 1'b0;
    // Offset 1 looks at last+1 first; offset n wraps back to last itself.
    for (int k = 1; k <= RR_MAX; k++) begin
      if (k <= n) begin
        idx = (int'(last) + k) % n;
        if (!found && req[idx]) begin
          win[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/wb_arb_rr_picker.sv
// wb_arb_rr_picker
// Combinational round-robin priority search.
//   req     : request vector, one bit per master
//   last    : index of the most recently granted master
//   win     : one-hot winner (all zero when req is zero)
//   win_idx : binary index of the winner (0 when req is zero)
module wb_arb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  localparam int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic [NUM_MASTERS-1:0] win,
  output logic [IDX_W-1:0]       win_idx
);

  logic [RR_MAX-1:0] req_pad;
  logic [2:0]        last_pad;
  logic [RR_MAX-1:0] pick;

  always_comb begin
    req_pad                  = '0;
    req_pad[NUM_MASTERS-1:0] = req;
    last_pad                 = 3'(last);
    pick                     = rr_pick(req_pad, last_pad, NUM_MASTERS);
    win_idx                  = '0;
    for (int i = 0; i < RR_MAX; i++) begin
      if (pick[i]) win_idx = IDX_W'(i);
    end
  end

  assign win = pick[NUM_MASTERS-1:0];

endmodule

// File: rtl/wb_ibex_arbiter.sv
// wb_ibex_arbiter
// Round-robin arbiter sharing one Wishbone B4 pipelined slave between
// NUM_MASTERS masters. A master keeps the grant for as long as it holds CYC;
// accepted-but-unanswered requests are counted and the granted master is
// stalled once MAX_OUTSTANDING of them are in flight.
//   clk, rst                     : clock, asynchronous active-high reset
//   m_cyc/m_stb/m_we/m_sel/m_adr/m_dat_w : per-master requests (slice i = master i)
//   m_dat_r                      : read data broadcast to every master
//   m_ack/m_err/m_stall          : per-master responses
//   s_*                          : single slave-side port
//   grant                        : one-hot current owner, zero when idle
module wb_ibex_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_cyc,
  input  logic [NUM_MASTERS-1:0]          m_stb,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_w,
  output logic [DATA_W-1:0]               m_dat_r,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [NUM_MASTERS-1:0]          m_err,
  output logic [NUM_MASTERS-1:0]          m_stall,
  output logic                            s_cyc,
  output logic                            s_stb,
  output logic                            s_we,
  output logic [DATA_W/8-1:0]             s_sel,
  output logic [ADDR_W-1:0]               s_adr,
  output logic [DATA_W-1:0]               s_dat_w,
  input  logic [DATA_W-1:0]               s_dat_r,
  input  logic                            s_ack,
  input  logic                            s_err,
  input  logic                            s_stall,
  output logic [NUM_MASTERS-1:0]          grant
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e             state_reg;
  logic [NUM_MASTERS-1:0] grant_reg;
  logic [IDX_W-1:0]       gidx_reg;
  logic [IDX_W-1:0]       last_reg;
  logic [CNT_W-1:0]       outs_reg;
  logic [CNT_W-1:0]       outs_next;

  logic [NUM_MASTERS-1:0] pick_win;
  logic [IDX_W-1:0]       pick_idx;
  logic                   busy;
  logic                   g_cyc;
  logic                   throttle;
  logic                   accept;
  logic                   resp;

  wb_arb_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .req    (m_cyc),
    .last   (last_reg),
    .win    (pick_win),
    .win_idx(pick_idx)
  );

  assign busy     = (state_reg == BUSY);
  assign g_cyc    = m_cyc[gidx_reg];
  // Throttle looks only at the registered count, so a response arriving
  // while full does not release the stall until the next cycle.
  assign throttle = busy && (outs_reg == CNT_W'(MAX_OUTSTANDING));

  assign s_cyc   = busy & g_cyc;
  assign s_stb   = s_cyc & m_stb[gidx_reg] & ~throttle;
  assign s_we    = m_we[gidx_reg];
  assign s_sel   = m_sel[gidx_reg*SEL_W +: SEL_W];
  assign s_adr   = m_adr[gidx_reg*ADDR_W +: ADDR_W];
  assign s_dat_w = m_dat_w[gidx_reg*DATA_W +: DATA_W];
  assign m_dat_r = s_dat_r;
  assign grant   = grant_reg;

  // grant_reg is zero in IDLE, so every master sees stall and no responses.
  // Gating with s_cyc drops responses that land in the release cycle.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
    assign m_ack[gi]   = grant_reg[gi] & s_ack & s_cyc;
    assign m_err[gi]   = grant_reg[gi] & s_err & s_cyc;
    assign m_stall[gi] = ~grant_reg[gi] | s_stall | throttle;
  end

  assign accept = s_stb & ~s_stall;
  assign resp   = s_cyc & (s_ack | s_err);

  always_comb begin
    outs_next = outs_reg;
    if (accept && !resp) begin
      outs_next = outs_reg + CNT_W'(1);
    end else if (!accept && resp && (outs_reg != '0)) begin
      outs_next = outs_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      gidx_reg  <= '0;
      last_reg  <= IDX_W'(NUM_MASTERS - 1);
      outs_reg  <= '0;
    end else if (state_reg == IDLE) begin
      outs_reg <= '0;
      if (|m_cyc) begin
        state_reg <= BUSY;
        grant_reg <= pick_win;
        gidx_reg  <= pick_idx;
      end
    end else begin
      if (!g_cyc) begin
        // Dropping CYC abandons anything still in flight.
        state_reg <= IDLE;
        grant_reg <= '0;
        last_reg  <= gidx_reg;
        outs_reg  <= '0;
      end else begin
        outs_reg <= outs_next;
      end
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding means the slave broke protocol.
  always_ff @(posedge clk) begin
    if (!rst && resp) begin
      assert (outs_reg != '0);
    end
  end
`endif

endmodule

// File: doc/wb_ibex_arbiter.md
Name: wb_ibex_arbiter

Overview:
- Round-robin arbiter sharing one Wishbone B4 pipelined slave port between N masters, e.g. the instruction and data ports of the Wishbone Ibex core driving one memory or interconnect.
- Grants one master per bus cycle (CYC high) and holds the grant until that master drops CYC.
- Tracks outstanding pipelined requests and throttles the granted master at a configurable depth.
- Sits between the core's Wishbone master ports and the system crossbar or memory.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8); index 0 has highest priority after reset.
- ADDR_W, 32, Wishbone address width.
- DATA_W, 32, Wishbone data width; SEL width is DATA_W/8.
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered requests (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- m_cyc  in  NUM_MASTERS  per-master CYC
- m_stb  in  NUM_MASTERS  per-master STB
- m_we  in  NUM_MASTERS  per-master WE
- m_sel  in  NUM_MASTERS*DATA_W/8  per-master SEL, master i at slice i
- m_adr  in  NUM_MASTERS*ADDR_W  per-master ADR
- m_dat_w  in  NUM_MASTERS*DATA_W  per-master write data
- m_dat_r  out  DATA_W  read data, broadcast to all masters
- m_ack  out  NUM_MASTERS  per-master ACK
- m_err  out  NUM_MASTERS  per-master ERR
- m_stall  out  NUM_MASTERS  per-master STALL
- s_cyc, s_stb, s_we  out  1  slave-side controls
- s_sel  out  DATA_W/8  slave SEL
- s_adr  out  ADDR_W  slave ADR
- s_dat_w  out  DATA_W  slave write data
- s_dat_r  in  DATA_W  slave read data
- s_ack, s_err, s_stall  in  1  slave responses
- grant  out  NUM_MASTERS  one-hot current grant, all zero when idle (debug/observability)

Behaviour:
- Reset (async assert, sync release): state IDLE, grant=0, outstanding=0, last-granted pointer = NUM_MASTERS-1 (so master 0 wins first). Outputs: s_cyc=0, s_stb=0, m_ack=0, m_err=0, m_stall=all ones.
- FSM has two states, IDLE and BUSY.
- IDLE: sample m_cyc. If any bit is set, register the winner and go to BUSY. The winner is the first set bit searching upward from last+1 with wrap-around. Latency from m_cyc to s_cyc is one cycle. While in IDLE, all m_stall=1 and s_cyc=0.
- BUSY, granted master g:
  - s_cyc = m_cyc[g].
  - s_stb = m_stb[g] & ~throttle.
  - s_we, s_sel, s_adr and s_dat_w are muxed from g.
  - m_ack[g] = s_ack & s_cyc and m_err[g] = s_err & s_cyc. Non-granted masters get ack=0, err=0, stall=1.
  - m_stall[g] = s_stall | throttle, where throttle = (outstanding == MAX_OUTSTANDING).
- Outstanding counter, width clog2(MAX_OUTSTANDING+1):
  - +1 on an accepted request (s_stb & ~s_stall).
  - −1 on a response (s_ack | s_err).
  - Accept and response in the same cycle leave it unchanged.
  - A response while outstanding==0 is ignored and the counter saturates at 0. This is a slave protocol violation; the sim-only assertion flags it.
- Release: when m_cyc[g] falls, go to IDLE next cycle, set last=g, clear outstanding (Wishbone CYC drop aborts pending responses), grant=0.
  - Responses arriving in the release cycle or later are not forwarded.
  - No master is granted in the cycle the FSM is back in IDLE. This one-cycle turnaround is mandatory.
- Throttling never blocks responses. At MAX_OUTSTANDING, a response in the same cycle does not unthrottle that cycle; throttle is computed from the registered count only.
- Simultaneous requests: strict round-robin from last+1. A master holding CYC continuously keeps the grant indefinitely; no preemption.
- Reset mid-transaction: all state cleared immediately; s_cyc falls asynchronously with rst.
- NUM_MASTERS=1 degenerates to pass-through with the one-cycle grant latency and throttle still present.

Decomposition:
- Package wb_arb_pkg holds the arb_state_e enum (IDLE, BUSY) and the function rr_pick(req, last), which returns the one-hot next winner.
- Sub-module wb_arb_rr_picker: combinational round-robin priority search, parameterised by NUM_MASTERS. It is reusable by later crossbar work.
- The main module holds the FSM, the outstanding counter and the muxes.

Test Plan:
- Single master: m_cyc[0]=1 at cycle 0, stb with adr 0x100 → s_cyc=1 at cycle 1, s_adr=0x100, grant=01; ack routed to m_ack[0] only, m_ack[1]=0.
- Contention: m_cyc=2'b11 together from reset → master 0 is granted first. Master 0 drops CYC → IDLE for one cycle → master 1 granted; master 0 re-requests → master 0 granted after master 1 releases.
- Throttle: MAX_OUTSTANDING=2, slave s_stall=0 with no acks, master streams 4 requests → 2 accepted, m_stall[g]=1 from the 3rd request. One s_ack → outstanding=1 and stall drops the following cycle.
- Concurrent accept+ack at outstanding=1 → count stays 1. ERR response → m_err[g]=1 and count decrements.
- Abort: master drops CYC with 3 outstanding → next cycle IDLE, outstanding=0, and a late s_ack produces no m_ack.
- Async reset asserted mid-BUSY → s_cyc=0 and m_stall=all ones in the same cycle. After release, master 0 has priority again.
